// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: the ALU always wins the write port, and multdiv
// results are written directly when the port is free or else held in a small FIFO.
// Optional feature macro: WB_EXC_EN (exception requests write their code to r30).
module wb_arbiter #(
    parameter int unsigned MD_DEPTH = 2
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        alu_exc,
    input  logic [31:0] alu_exc_code,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    input  logic        md_exc,
    input  logic [31:0] md_exc_code,
    output logic        md_ready,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic [31:0] pend_mask,
    output logic [2:0]  md_count
);

    localparam int unsigned PtrW   = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
    localparam logic [2:0]  DepthC = 3'(MD_DEPTH);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MD_DEPTH - 1);

    // Effective target/data after exception remapping
    logic [4:0]  alu_tgt;
    logic [31:0] alu_wdat;
    logic [4:0]  md_tgt;
    logic [31:0] md_wdat;

`ifdef WB_EXC_EN
    assign alu_tgt  = alu_exc ? 5'd30 : alu_rd;
    assign alu_wdat = alu_exc ? alu_exc_code : alu_data;
    assign md_tgt   = md_exc ? 5'd30 : md_rd;
    assign md_wdat  = md_exc ? md_exc_code : md_data;
`else
    logic unused_exc;
    assign unused_exc = ^{alu_exc, alu_exc_code, md_exc, md_exc_code};
    assign alu_tgt    = alu_rd;
    assign alu_wdat   = alu_data;
    assign md_tgt     = md_rd;
    assign md_wdat    = md_data;
`endif

    // Buffer storage and bookkeeping
    logic [4:0]      buf_reg_q [MD_DEPTH];
    logic [31:0]     buf_dat_q [MD_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0]      count_q, count_d;

    // Registered write port
    logic        we_q, we_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdat_q, wdat_d;

    logic alu_eff;
    logic md_acc;
    logic md_eff;
    logic push;
    logic pop;

    // Ready depends only on registered occupancy, so a popping full buffer still refuses
    assign md_ready = (count_q < DepthC);
    assign md_acc   = md_valid && md_ready;
    assign md_eff   = md_acc && (md_tgt != 5'd0);
    assign alu_eff  = alu_valid && (alu_tgt != 5'd0);

    // Select the single write for this cycle and decide buffer push/pop
    always_comb begin
        we_d     = 1'b0;
        wreg_d   = wreg_q;
        wdat_d   = wdat_q;
        pop      = 1'b0;
        push     = 1'b0;
        if (alu_eff) begin
            we_d   = 1'b1;
            wreg_d = alu_tgt;
            wdat_d = alu_wdat;
            push   = md_eff;
        end else if (count_q != 3'd0) begin
            we_d   = 1'b1;
            wreg_d = buf_reg_q[rd_ptr_q];
            wdat_d = buf_dat_q[rd_ptr_q];
            pop    = 1'b1;
            push   = md_eff;
        end else if (md_eff) begin
            // Bypass: empty buffer and free port, write straight through
            we_d   = 1'b1;
            wreg_d = md_tgt;
            wdat_d = md_wdat;
        end
        rd_ptr_d = pop  ? ((rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1)) : rd_ptr_q;
        wr_ptr_d = push ? ((wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1)) : wr_ptr_q;
        count_d  = count_q + {2'b00, push} - {2'b00, pop};
    end

    // State registers with asynchronous clear
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            we_q     <= 1'b0;
            wreg_q   <= 5'd0;
            wdat_q   <= 32'd0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= 3'd0;
            for (int unsigned i = 0; i < MD_DEPTH; i++) begin
                buf_reg_q[i] <= 5'd0;
                buf_dat_q[i] <= 32'd0;
            end
        end else begin
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdat_q   <= wdat_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                buf_reg_q[wr_ptr_q] <= md_tgt;
                buf_dat_q[wr_ptr_q] <= md_wdat;
            end
        end
    end

    // Pending mask: OR of one-hot targets of the occupied slots, walking from the head
    always_comb begin
        pend_mask = 32'd0;
        for (int unsigned k = 0; k < MD_DEPTH; k++) begin
            if (3'(k) < count_q) begin
                pend_mask[buf_reg_q[PtrW'((32'(rd_ptr_q) + k) % MD_DEPTH)]] = 1'b1;
            end
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdat_q;
    assign md_count         = count_q;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter MD_DEPTH, default 2, multdiv result buffer depth (legal: 2, 4).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port ctrl_reset  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 SHALL have ports alu_valid/alu_rd/alu_data  input  1/5/32  ALU writeback request, destination, data.
REQ-005 SHALL have ports alu_exc/alu_exc_code  input  1/32  ALU overflow flag, rstatus value.
REQ-006 SHALL have ports md_valid/md_rd/md_data  input  1/5/32  multdiv result request, destination, data.
REQ-007 SHALL have ports md_exc/md_exc_code  input  1/32  multdiv exception flag, rstatus value.
REQ-008 SHALL have port md_ready  output  1  multdiv result accepted this cycle when md_valid=1.
REQ-009 SHALL have ports ctrl_writeEnable/ctrl_writeReg/data_writeReg  output  1/5/32  register-file write port, registered.
REQ-010 SHALL have port pend_mask  output  32  bit i=1 when a buffered multdiv entry targets register i.
REQ-011 SHALL have port md_count  output  3  number of buffered multdiv entries.

Function
REQ-012 SHALL issue at most one register-file write per cycle; a request selected in cycle N appears on the write port in cycle N+1 for exactly one cycle.
REQ-013 SHALL treat an ALU request as effective when alu_valid=1 and target register is non-zero.
REQ-014 SHALL give an effective ALU request absolute priority; ALU is never stalled.
REQ-015 SHALL, when no effective ALU request is present and buffer is non-empty, pop buffer head and write it.
REQ-016 SHALL, when no effective ALU request is present and buffer is empty, write an accepted multdiv result directly (bypass, not enqueued, md_count unchanged).
REQ-017 SHALL otherwise enqueue an accepted multdiv result at buffer tail; pop and push in the same cycle are both legal.
REQ-018 SHALL drive md_ready=1 iff md_count<MD_DEPTH, computed from registered count only (no accept into a full buffer even while popping).
REQ-019 SHALL accept and discard multdiv results whose target register is 0 (no enqueue, no write).
REQ-020 SHALL write buffered results in arrival order; no reordering against ALU writes to the same register (pipeline uses pend_mask to avoid that hazard).
REQ-021 SHALL compute pend_mask combinationally as OR of one-hot targets of all valid buffer entries; buffer pointers wrap modulo MD_DEPTH.
REQ-022 SHALL hold ctrl_writeEnable=0 and hold ctrl_writeReg/data_writeReg at previous values in cycles with no write.

Reset
REQ-023 SHALL, on ctrl_reset=0, immediately clear buffer (md_count=0, pend_mask=0), ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, pointers=0.
REQ-024 SHALL drop in-flight and buffered results on reset mid-operation; no write is issued in the first edge after reset deasserts unless a request is present then.

Configuration
REQ-025 SHALL support macro WB_EXC_EN: when defined, a request with exc=1 writes its exc_code to register 30 regardless of rd (rd=0 included), and pend_mask counts it as register 30.
REQ-026 SHALL, when WB_EXC_EN is undefined, ignore alu_exc/md_exc and their codes; data goes to rd as normal.

Verification
REQ-027 ALU only: alu_valid=1, rd=5, data=0x0000_00AA -> next cycle WE=1, reg=5, data=0xAA; md_count stays 0.
REQ-028 Collision: alu rd=3 and md rd=7 data=0x1234 same cycle -> cycle+1 writes r3; cycle+2 (ALU idle) writes r7=0x1234; pend_mask=0x80 between.
REQ-029 Full: MD_DEPTH=2, ALU busy 4 cycles, md_valid held with rd=8,9,10 -> md_ready=0 after two accepts, md_count=2, rd=10 held until pop; writes r8,r9,r10 in order.
REQ-030 Zero register: alu rd=0 and md rd=4 same cycle, buffer empty -> r4 written next cycle via bypass, r0 never written.
REQ-031 Exception (WB_EXC_EN): alu_exc=1, code=0x1, rd=6 -> next cycle write r30=0x1, r6 untouched; without macro r6=alu_data.
REQ-032 Reset mid-op: two entries buffered, ctrl_reset=0 -> WE=0, md_count=0, pend_mask=0 immediately; no stale write after release.
